// File: rtl/wb_retire_queue.sv
// rtl/wb_retire_queue.sv - in-order writeback retire queue with CSR-read wait, flush and forwarding
module wb_retire_queue #(
  parameter int DEPTH      = 2,
  parameter int CSR_RD_LAT = 1,
  parameter int NUM_FWD    = 2,
  parameter int DATA_W     = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      mem_to_wb_valid,
  output logic                      wb_allowin,
  input  logic                      in_rf_we,
  input  logic [4:0]                in_rf_waddr,
  input  logic [DATA_W-1:0]         in_rf_wdata,
  input  logic [31:0]               in_pc,
  input  logic                      in_csr_re,
  input  logic                      in_csr_we,
  input  logic [13:0]               in_csr_num,
  input  logic [DATA_W-1:0]         in_csr_wmask,
  input  logic [DATA_W-1:0]         in_csr_wvalue,
  input  logic                      in_ex,
  input  logic [5:0]                in_ecode,
  input  logic [8:0]                in_esubcode,
  input  logic                      in_ertn,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      csr_re,
  output logic [13:0]               csr_num,
  input  logic [DATA_W-1:0]         csr_rvalue,
  output logic                      csr_we,
  output logic [DATA_W-1:0]         csr_wmask,
  output logic [DATA_W-1:0]         csr_wvalue,
  output logic                      wb_ex,
  output logic                      wb_ex_valid,
  output logic [31:0]               wb_ex_pc,
  output logic [5:0]                wb_ecode,
  output logic [8:0]                wb_esubcode,
  output logic                      wb_is_ertn,
  input  logic [NUM_FWD*5-1:0]      fwd_raddr,
  output logic [NUM_FWD-1:0]        fwd_hit,
  output logic [NUM_FWD-1:0]        fwd_stall,
  output logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [31:0]               debug_wb_pc,
  output logic [3:0]                debug_wb_rf_we,
  output logic [4:0]                debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata,
  output logic [31:0]               retire_cnt
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  typedef enum logic {IDLE, CSR_WAIT} state_t;

  logic              q_rf_we    [DEPTH];
  logic [4:0]        q_waddr    [DEPTH];
  logic [DATA_W-1:0] q_wdata    [DEPTH];
  logic [31:0]       q_pc       [DEPTH];
  logic              q_csr_re   [DEPTH];
  logic              q_csr_we   [DEPTH];
  logic [13:0]       q_csr_num  [DEPTH];
  logic [DATA_W-1:0] q_csr_wmask[DEPTH];
  logic [DATA_W-1:0] q_csr_wval [DEPTH];
  logic              q_ex       [DEPTH];
  logic [5:0]        q_ecode    [DEPTH];
  logic [8:0]        q_esub     [DEPTH];
  logic              q_ertn     [DEPTH];

  logic [AW-1:0]    head_ptr, tail_ptr;
  logic [CNT_W-1:0] count;
  state_t           state, state_n;
  logic [2:0]       wait_cnt, wait_n;
  logic             empty, flush, retire, push;

  assign empty      = (count == '0);
  assign wb_allowin = (count != CNT_W'(DEPTH));
  assign flush      = !empty && (q_ex[head_ptr] || q_ertn[head_ptr]);
  // a flushing head discards whatever MEM offers in the same cycle
  assign push       = mem_to_wb_valid && wb_allowin && !flush;

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    retire  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !flush) begin
          if (q_csr_re[head_ptr] && CSR_RD_LAT != 0) begin
            state_n = CSR_WAIT;
            wait_n  = 3'(CSR_RD_LAT);
          end else begin
            retire = 1'b1;
          end
        end
      end
      CSR_WAIT: begin
        wait_n = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) begin
          retire  = 1'b1;
          state_n = IDLE;
          wait_n  = 3'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count      <= '0;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      retire_cnt <= 32'd0;
    end else if (flush) begin
      count    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      if (push)   tail_ptr <= tail_ptr + AW'(1);
      if (retire) begin
        head_ptr   <= head_ptr + AW'(1);
        retire_cnt <= retire_cnt + 32'd1;
      end
      case ({push, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rf_we[tail_ptr]     <= in_rf_we;
      q_waddr[tail_ptr]     <= in_rf_waddr;
      q_wdata[tail_ptr]     <= in_rf_wdata;
      q_pc[tail_ptr]        <= in_pc;
      q_csr_re[tail_ptr]    <= in_csr_re;
      q_csr_we[tail_ptr]    <= in_csr_we;
      q_csr_num[tail_ptr]   <= in_csr_num;
      q_csr_wmask[tail_ptr] <= in_csr_wmask;
      q_csr_wval[tail_ptr]  <= in_csr_wvalue;
      q_ex[tail_ptr]        <= in_ex;
      q_ecode[tail_ptr]     <= in_ecode;
      q_esub[tail_ptr]      <= in_esubcode;
      q_ertn[tail_ptr]      <= in_ertn;
    end
  end

  assign rf_we       = retire && q_rf_we[head_ptr];
  assign rf_waddr    = empty ? '0 : q_waddr[head_ptr];
  assign rf_wdata    = empty ? '0 : (q_csr_re[head_ptr] ? csr_rvalue : q_wdata[head_ptr]);
  assign csr_re      = !empty && !flush && q_csr_re[head_ptr];
  assign csr_num     = empty ? '0 : q_csr_num[head_ptr];
  assign csr_we      = retire && q_csr_we[head_ptr];
  assign csr_wmask   = empty ? '0 : q_csr_wmask[head_ptr];
  assign csr_wvalue  = empty ? '0 : q_csr_wval[head_ptr];
  assign wb_ex       = flush;
  assign wb_ex_valid = flush && q_ex[head_ptr];
  assign wb_is_ertn  = flush && q_ertn[head_ptr];
  assign wb_ex_pc    = flush ? q_pc[head_ptr] : 32'd0;
  assign wb_ecode    = flush ? q_ecode[head_ptr] : 6'd0;
  assign wb_esubcode = flush ? q_esub[head_ptr] : 9'd0;

  assign debug_wb_pc       = empty ? 32'd0 : q_pc[head_ptr];
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    logic [4:0]        raddr;
    logic [AW-1:0]     idx;
    logic              hit, m_csr, m_head;
    logic [DATA_W-1:0] m_data;
    fwd_hit   = '0;
    fwd_stall = '0;
    fwd_data  = '0;
    for (int p = 0; p < NUM_FWD; p++) begin
      raddr  = fwd_raddr[5*p +: 5];
      hit    = 1'b0;
      m_csr  = 1'b0;
      m_head = 1'b0;
      m_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + AW'(k);
        if (CNT_W'(k) < count && q_rf_we[idx] && q_waddr[idx] == raddr &&
            raddr != 5'd0 && !q_ex[idx] && !q_ertn[idx]) begin
          hit    = 1'b1;
          m_csr  = q_csr_re[idx];
          m_head = (k == 0);
          m_data = q_wdata[idx];
        end
      end
      fwd_hit[p]                 = hit;
      fwd_stall[p]               = hit && m_csr && !(m_head && retire);
      fwd_data[p*DATA_W +: DATA_W] = (hit && m_csr && m_head && retire) ? csr_rvalue : m_data;
    end
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// tb/tb_wb_retire_queue.sv - self-checking bench for wb_retire_queue
module tb_wb_retire_queue;
  localparam int DEPTH = 2;
  localparam int LAT   = 3;
  localparam int NF    = 2;
  localparam int DW    = 32;

  typedef struct {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        ertn;
  } ent_t;

  logic clk, resetn, mem_to_wb_valid, wb_allowin;
  logic in_rf_we, in_csr_re, in_csr_we, in_ex, in_ertn;
  logic [4:0] in_rf_waddr;
  logic [DW-1:0] in_rf_wdata, in_csr_wmask, in_csr_wvalue;
  logic [31:0] in_pc;
  logic [13:0] in_csr_num;
  logic [5:0] in_ecode;
  logic [8:0] in_esubcode;
  logic rf_we, csr_re, csr_we, wb_ex, wb_ex_valid, wb_is_ertn;
  logic [4:0] rf_waddr, debug_wb_rf_wnum;
  logic [DW-1:0] rf_wdata, csr_rvalue, csr_wmask, csr_wvalue, debug_wb_rf_wdata;
  logic [13:0] csr_num;
  logic [31:0] wb_ex_pc, debug_wb_pc, retire_cnt;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic [3:0] debug_wb_rf_we;
  logic [NF*5-1:0] fwd_raddr;
  logic [NF-1:0] fwd_hit, fwd_stall;
  logic [NF*DW-1:0] fwd_data;

  int errors = 0;
  int checks = 0;

  ent_t        mq[$];
  int          m_age;
  logic [31:0] m_rcnt;

  wb_retire_queue #(.DEPTH(DEPTH), .CSR_RD_LAT(LAT), .NUM_FWD(NF), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn), .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata), .in_pc(in_pc),
    .in_csr_re(in_csr_re), .in_csr_we(in_csr_we), .in_csr_num(in_csr_num),
    .in_csr_wmask(in_csr_wmask), .in_csr_wvalue(in_csr_wvalue),
    .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode), .in_ertn(in_ertn),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ex_valid(wb_ex_valid), .wb_ex_pc(wb_ex_pc), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_is_ertn(wb_is_ertn),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_stall(fwd_stall), .fwd_data(fwd_data),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t mk(input logic we, input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] pc);
    ent_t e;
    e = '{default: '0};
    e.rf_we = we;
    e.waddr = a;
    e.wdata = d;
    e.pc    = pc;
    return e;
  endfunction

  task automatic set_in(input ent_t e, input logic v);
    mem_to_wb_valid = v;
    in_rf_we        = e.rf_we;
    in_rf_waddr     = e.waddr;
    in_rf_wdata     = e.wdata;
    in_pc           = e.pc;
    in_csr_re       = e.csr_re;
    in_csr_we       = e.csr_we;
    in_csr_num      = e.csr_num;
    in_csr_wmask    = e.wmask;
    in_csr_wvalue   = e.wvalue;
    in_ex           = e.ex;
    in_ecode        = e.ecode;
    in_esubcode     = e.esub;
    in_ertn         = e.ertn;
  endtask

  task automatic idle_in();
    set_in(mk(1'b0, 5'd0, 32'd0, 32'd0), 1'b0);
    csr_rvalue = '0;
    fwd_raddr  = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    fwd_raddr = {5'd3, 5'd1};
    #1;
    checks++;
    if (wb_allowin !== 1'b1 || rf_we !== 1'b0 || retire_cnt !== 32'd0 || debug_wb_pc !== 32'd0 ||
        wb_ex !== 1'b0 || csr_re !== 1'b0 || fwd_hit !== 2'b00 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state allowin=%b rf_we=%b cnt=%h pc=%h ex=%b csr_re=%b hit=%b wdata=%h required 1/0/0/0/0/0/00/0",
               wb_allowin, rf_we, retire_cnt, debug_wb_pc, wb_ex, csr_re, fwd_hit, rf_wdata);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(mk(1'b1, 5'd1, 32'hA1, 32'h1c000000), 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(mk(1'b1, 5'd2, 32'hA2, 32'h1c000004), 1'b1);
    #1;
    checks++;
    if (rf_we !== 1'b1 || debug_wb_pc !== 32'h1c000000 || rf_wdata !== 32'hA1 || rf_waddr !== 5'd1 ||
        debug_wb_rf_we !== 4'hf) begin
      errors++;
      $display("FAIL b2b_first rf_we=%b pc=%h data=%h addr=%0d dbg_we=%h required 1/1c000000/a1/1/f",
               rf_we, debug_wb_pc, rf_wdata, rf_waddr, debug_wb_rf_we);
    end
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if (rf_we !== 1'b1 || debug_wb_pc !== 32'h1c000004 || rf_wdata !== 32'hA2) begin
      errors++;
      $display("FAIL b2b_second rf_we=%b pc=%h data=%h required 1/1c000004/a2", rf_we, debug_wb_pc, rf_wdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf_we !== 1'b0 || retire_cnt !== 32'd2 || wb_allowin !== 1'b1 || debug_wb_pc !== 32'd0) begin
      errors++;
      $display("FAIL b2b_drain rf_we=%b cnt=%0d allowin=%b pc=%h required 0/2/1/0", rf_we, retire_cnt, wb_allowin, debug_wb_pc);
    end
  endtask

  task automatic test_full();
    ent_t e;
    do_reset();
    e = mk(1'b1, 5'd3, 32'd0, 32'h1c000010);
    e.csr_re = 1'b1;
    e.csr_num = 14'h5;
    set_in(e, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(mk(1'b1, 5'd8, 32'h88, 32'h1c000014), 1'b1);
    #1;
    checks++;
    if (wb_allowin !== 1'b1 || csr_re !== 1'b1 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL full_head_wait allowin=%b csr_re=%b rf_we=%b required 1/1/0", wb_allowin, csr_re, rf_we);
    end
    @(negedge clk);
    set_in(mk(1'b1, 5'd9, 32'h99, 32'h1c000018), 1'b1);
    #1;
    checks++;
    if (wb_allowin !== 1'b0 || csr_num !== 14'h5 || rf_we !== 1'b0 || csr_re !== 1'b1) begin
      errors++;
      $display("FAIL full_block allowin=%b csr_num=%h rf_we=%b csr_re=%b required 0/5/0/1", wb_allowin, csr_num, rf_we, csr_re);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wb_allowin !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL full_wait2 allowin=%b rf_we=%b required 0/0", wb_allowin, rf_we);
    end
    @(negedge clk);
    csr_rvalue = 32'hCAFE0001;
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'hCAFE0001 || rf_waddr !== 5'd3 || wb_allowin !== 1'b0) begin
      errors++;
      $display("FAIL full_csr_retire rf_we=%b data=%h addr=%0d allowin=%b required 1/cafe0001/3/0",
               rf_we, rf_wdata, rf_waddr, wb_allowin);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wb_allowin !== 1'b1 || rf_we !== 1'b1 || debug_wb_pc !== 32'h1c000014 || rf_wdata !== 32'h88) begin
      errors++;
      $display("FAIL full_second allowin=%b rf_we=%b pc=%h data=%h required 1/1/1c000014/88",
               wb_allowin, rf_we, debug_wb_pc, rf_wdata);
    end
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if (rf_we !== 1'b1 || debug_wb_pc !== 32'h1c000018) begin
      errors++;
      $display("FAIL full_third rf_we=%b pc=%h required 1/1c000018", rf_we, debug_wb_pc);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf_we !== 1'b0 || retire_cnt !== 32'd3 || wb_allowin !== 1'b1) begin
      errors++;
      $display("FAIL full_drain rf_we=%b cnt=%0d allowin=%b required 0/3/1", rf_we, retire_cnt, wb_allowin);
    end
  endtask

  task automatic test_flush();
    ent_t e;
    do_reset();
    set_in(mk(1'b1, 5'd4, 32'h44, 32'h1c000100), 1'b1);
    @(posedge clk);
    @(negedge clk);
    e = mk(1'b1, 5'd12, 32'h0, 32'h1c000104);
    e.ex = 1'b1;
    e.ecode = 6'hB;
    set_in(e, 1'b1);
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || wb_ex !== 1'b0) begin
      errors++;
      $display("FAIL flush_r4 rf_we=%b addr=%0d ex=%b required 1/4/0", rf_we, rf_waddr, wb_ex);
    end
    @(negedge clk);
    set_in(mk(1'b1, 5'd5, 32'h55, 32'h1c000108), 1'b1);
    #1;
    checks++;
    if (wb_ex !== 1'b1 || wb_ex_valid !== 1'b1 || wb_ecode !== 6'hB || wb_ex_pc !== 32'h1c000104 ||
        rf_we !== 1'b0 || wb_is_ertn !== 1'b0 || csr_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_ex ex=%b valid=%b ecode=%h pc=%h rf_we=%b ertn=%b csr_we=%b required 1/1/b/1c000104/0/0/0",
               wb_ex, wb_ex_valid, wb_ecode, wb_ex_pc, rf_we, wb_is_ertn, csr_we);
    end
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if (wb_ex !== 1'b0 || rf_we !== 1'b0 || debug_wb_pc !== 32'd0 || retire_cnt !== 32'd1 || wb_allowin !== 1'b1) begin
      errors++;
      $display("FAIL flush_after ex=%b rf_we=%b pc=%h cnt=%0d allowin=%b required 0/0/0/1/1",
               wb_ex, rf_we, debug_wb_pc, retire_cnt, wb_allowin);
    end
  endtask

  task automatic test_forwarding();
    ent_t e;
    do_reset();
    e = mk(1'b1, 5'd7, 32'h0, 32'h1c000300);
    e.csr_re = 1'b1;
    set_in(e, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(mk(1'b1, 5'd6, 32'h22, 32'h1c000304), 1'b1);
    @(negedge clk);
    idle_in();
    fwd_raddr = {5'd6, 5'd7};
    #1;
    checks++;
    if (fwd_hit !== 2'b11 || fwd_stall !== 2'b01 || fwd_data[DW +: DW] !== 32'h22) begin
      errors++;
      $display("FAIL fwd_pending hit=%b stall=%b data1=%h required 11/01/22", fwd_hit, fwd_stall, fwd_data[DW +: DW]);
    end
    @(negedge clk);
    fwd_raddr = {5'd5, 5'd0};
    #1;
    checks++;
    if (fwd_hit !== 2'b00 || fwd_stall !== 2'b00 || fwd_data !== '0) begin
      errors++;
      $display("FAIL fwd_miss hit=%b stall=%b data=%h required 00/00/0", fwd_hit, fwd_stall, fwd_data);
    end
    @(negedge clk);
    fwd_raddr  = {5'd6, 5'd7};
    csr_rvalue = 32'h77;
    #1;
    checks++;
    if (fwd_hit[0] !== 1'b1 || fwd_stall[0] !== 1'b0 || fwd_data[0 +: DW] !== 32'h77 || rf_we !== 1'b1) begin
      errors++;
      $display("FAIL fwd_csr_retire hit=%b stall=%b data0=%h rf_we=%b required 1/0/77/1",
               fwd_hit[0], fwd_stall[0], fwd_data[0 +: DW], rf_we);
    end
    @(negedge clk);
    idle_in();
    e = mk(1'b1, 5'd6, 32'h11, 32'h1c000308);
    e.csr_re = 1'b1;
    set_in(e, 1'b1);
    @(negedge clk);
    set_in(mk(1'b1, 5'd6, 32'h33, 32'h1c00030c), 1'b1);
    @(negedge clk);
    idle_in();
    fwd_raddr = {5'd0, 5'd6};
    #1;
    checks++;
    if (fwd_hit !== 2'b01 || fwd_stall !== 2'b00 || fwd_data[0 +: DW] !== 32'h33) begin
      errors++;
      $display("FAIL fwd_youngest hit=%b stall=%b data0=%h required 01/00/33", fwd_hit, fwd_stall, fwd_data[0 +: DW]);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (wb_allowin !== 1'b1 || rf_we !== 1'b0 || retire_cnt !== 32'd4) begin
      errors++;
      $display("FAIL fwd_drain allowin=%b rf_we=%b cnt=%0d required 1/0/4", wb_allowin, rf_we, retire_cnt);
    end
  endtask

  task automatic test_push_flush();
    ent_t e;
    do_reset();
    e = mk(1'b1, 5'd9, 32'h9, 32'h1c000400);
    e.ertn = 1'b1;
    set_in(e, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(mk(1'b1, 5'd10, 32'hA, 32'h1c000404), 1'b1);
    fwd_raddr = {5'd0, 5'd9};
    #1;
    checks++;
    if (wb_ex !== 1'b1 || wb_is_ertn !== 1'b1 || wb_ex_valid !== 1'b0 || rf_we !== 1'b0 || fwd_hit !== 2'b00) begin
      errors++;
      $display("FAIL ertn_flush ex=%b ertn=%b valid=%b rf_we=%b hit=%b required 1/1/0/0/00",
               wb_ex, wb_is_ertn, wb_ex_valid, rf_we, fwd_hit);
    end
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if (wb_ex !== 1'b0 || rf_we !== 1'b0 || debug_wb_pc !== 32'd0 || wb_allowin !== 1'b1 || retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL ertn_dropped ex=%b rf_we=%b pc=%h allowin=%b cnt=%0d required 0/0/0/1/0",
               wb_ex, rf_we, debug_wb_pc, wb_allowin, retire_cnt);
    end
  endtask

  task automatic test_reset_mid();
    ent_t e;
    do_reset();
    set_in(mk(1'b1, 5'd1, 32'h1, 32'h100), 1'b1);
    @(negedge clk);
    e = mk(1'b1, 5'd7, 32'h0, 32'h104);
    e.csr_re = 1'b1;
    e.csr_num = 14'h20;
    set_in(e, 1'b1);
    @(negedge clk);
    set_in(mk(1'b1, 5'd2, 32'h2, 32'h108), 1'b1);
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if (csr_re !== 1'b1 || wb_allowin !== 1'b0 || retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rstmid_pre csr_re=%b allowin=%b cnt=%0d required 1/0/1", csr_re, wb_allowin, retire_cnt);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (csr_re !== 1'b0 || rf_we !== 1'b0 || debug_wb_pc !== 32'd0 || wb_allowin !== 1'b1 ||
        retire_cnt !== 32'd0 || csr_num !== 14'd0) begin
      errors++;
      $display("FAIL rstmid_async csr_re=%b rf_we=%b pc=%h allowin=%b cnt=%0d num=%h required 0/0/0/1/0/0",
               csr_re, rf_we, debug_wb_pc, wb_allowin, retire_cnt, csr_num);
    end
    @(negedge clk);
    resetn = 1'b1;
    set_in(mk(1'b1, 5'd2, 32'h2, 32'h200), 1'b1);
    @(negedge clk);
    idle_in();
    #1;
    checks++;
    if (rf_we !== 1'b1 || debug_wb_pc !== 32'h200) begin
      errors++;
      $display("FAIL rstmid_resume rf_we=%b pc=%h required 1/200", rf_we, debug_wb_pc);
    end
  endtask

  task automatic test_random();
    ent_t e, h;
    logic v, x_empty, x_flush, x_retire, x_allow, x_we, eh, es;
    logic [4:0] r;
    logic [31:0] ed;
    do_reset();
    mq.delete();
    m_age  = 0;
    m_rcnt = 32'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      e = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      e.csr_re  = ($urandom_range(0, 3) == 0);
      e.csr_we  = ($urandom_range(0, 5) == 0);
      e.csr_num = 14'($urandom);
      e.wmask   = $urandom;
      e.wvalue  = $urandom;
      e.ex      = ($urandom_range(0, 15) == 0);
      e.ecode   = 6'($urandom);
      e.esub    = 9'($urandom);
      e.ertn    = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 9) < 7);
      set_in(e, v);
      csr_rvalue = $urandom;
      for (int p = 0; p < NF; p++) fwd_raddr[5*p +: 5] = 5'($urandom_range(0, 7));
      #1;
      x_empty  = (mq.size() == 0);
      h        = x_empty ? mk(1'b0, 5'd0, 32'd0, 32'd0) : mq[0];
      x_allow  = (mq.size() != DEPTH);
      x_flush  = !x_empty && (h.ex || h.ertn);
      x_retire = !x_empty && !x_flush && (!h.csr_re || m_age >= LAT);
      x_we     = x_retire && h.rf_we;
      checks++;
      if (wb_allowin !== x_allow) begin
        errors++;
        $display("FAIL rnd_allowin cyc=%0d got=%b exp=%b", cyc, wb_allowin, x_allow);
      end
      checks++;
      if (rf_we !== x_we || debug_wb_rf_we !== {4{x_we}}) begin
        errors++;
        $display("FAIL rnd_rf_we cyc=%0d got=%b/%h exp=%b", cyc, rf_we, debug_wb_rf_we, x_we);
      end
      checks++;
      if (rf_waddr !== h.waddr || rf_wdata !== (x_empty ? 32'd0 : (h.csr_re ? csr_rvalue : h.wdata))) begin
        errors++;
        $display("FAIL rnd_rf_data cyc=%0d got=%0d/%h exp=%0d/%h", cyc, rf_waddr, rf_wdata, h.waddr,
                 x_empty ? 32'd0 : (h.csr_re ? csr_rvalue : h.wdata));
      end
      checks++;
      if (csr_re !== (!x_empty && !x_flush && h.csr_re) || csr_we !== (x_retire && h.csr_we) ||
          csr_wvalue !== h.wvalue || csr_num !== h.csr_num) begin
        errors++;
        $display("FAIL rnd_csr cyc=%0d re=%b we=%b wv=%h num=%h exp %b/%b/%h/%h", cyc, csr_re, csr_we, csr_wvalue,
                 csr_num, !x_empty && !x_flush && h.csr_re, x_retire && h.csr_we, h.wvalue, h.csr_num);
      end
      checks++;
      if (wb_ex !== x_flush || wb_ex_valid !== (x_flush && h.ex) || wb_is_ertn !== (x_flush && h.ertn) ||
          wb_ex_pc !== (x_flush ? h.pc : 32'd0) || wb_ecode !== (x_flush ? h.ecode : 6'd0)) begin
        errors++;
        $display("FAIL rnd_ex cyc=%0d got=%b/%b/%b/%h/%h exp=%b/%b/%b/%h/%h", cyc, wb_ex, wb_ex_valid, wb_is_ertn,
                 wb_ex_pc, wb_ecode, x_flush, x_flush && h.ex, x_flush && h.ertn,
                 x_flush ? h.pc : 32'd0, x_flush ? h.ecode : 6'd0);
      end
      checks++;
      if (debug_wb_pc !== h.pc || retire_cnt !== m_rcnt) begin
        errors++;
        $display("FAIL rnd_pc_cnt cyc=%0d got=%h/%0d exp=%h/%0d", cyc, debug_wb_pc, retire_cnt, h.pc, m_rcnt);
      end
      for (int p = 0; p < NF; p++) begin
        r  = fwd_raddr[5*p +: 5];
        eh = 1'b0;
        es = 1'b0;
        ed = 32'd0;
        if (r != 5'd0) begin
          for (int k = mq.size() - 1; k >= 0; k--) begin
            if (mq[k].rf_we && mq[k].waddr == r && !mq[k].ex && !mq[k].ertn) begin
              eh = 1'b1;
              ed = mq[k].wdata;
              if (mq[k].csr_re) begin
                if (k == 0 && x_retire) ed = csr_rvalue;
                else es = 1'b1;
              end
              break;
            end
          end
        end
        checks++;
        if (fwd_hit[p] !== eh || fwd_stall[p] !== es || fwd_data[p*DW +: DW] !== ed) begin
          errors++;
          $display("FAIL rnd_fwd cyc=%0d port=%0d raddr=%0d got=%b/%b/%h exp=%b/%b/%h", cyc, p, r,
                   fwd_hit[p], fwd_stall[p], fwd_data[p*DW +: DW], eh, es, ed);
        end
      end
      @(posedge clk);
      if (x_flush) begin
        mq.delete();
        m_age = 0;
      end else begin
        if (x_retire) begin
          void'(mq.pop_front());
          m_age  = 0;
          m_rcnt = m_rcnt + 32'd1;
        end else if (!x_empty) begin
          m_age++;
        end
        if (v && x_allow) mq.push_back(e);
      end
      @(negedge clk);
    end
    idle_in();
  endtask

  initial begin
    resetn = 1'b0;
    idle_in();
    test_reset();
    test_back_to_back();
    test_full();
    test_flush();
    test_forwarding();
    test_push_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
